modulation_sequencer: RTL and testbench

- Sequences reads from the dual-port modulation BRAM: generates the 16-bit read address and registers the 8-bit sample for the transducer drive stage.
- Steps the address once every FREQ_DIV+1 sample ticks and wraps at a programmable cycle length.
- Configuration is double-buffered, so the CPU side can rewrite the cycle length and divider without glitching a running cycle.
- Sits between the CPU-facing config registers / timing block and modulation_buffer port B.

---
 rtl/modulation_pkg.sv | 17 +
 rtl/mod_cfg_shadow.sv | 47 ++++
 rtl/modulation_sequencer.sv | 143 ++++++++++++++
 tb/tb_modulation_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modulation_pkg.sv
// Shared types and constants for the modulation read sequencer.
package modulation_pkg;

  localparam int unsigned MOD_SAMPLE_WIDTH = 8;
  localparam int unsigned MOD_ADDR_WIDTH   = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [MOD_ADDR_WIDTH-1:0] cycle_last;
    logic [MOD_ADDR_WIDTH-1:0] freq_div;
  } mod_cfg_t;

endpackage

// File: rtl/mod_cfg_shadow.sv
// Double-buffered sequencer configuration: CPU writes land in a pending copy
// that is promoted to the active copy only when the sequencer asks for it.
module mod_cfg_shadow
  import modulation_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cfg_update_i,
  input  mod_cfg_t cfg_i,
  input  logic     apply_i,
  output mod_cfg_t active_o
);

  mod_cfg_t pend_q, pend_d;
  mod_cfg_t act_q, act_d;
  logic     flag_q, flag_d;

  // Promotion uses the old pending copy; a same-cycle update stays pending.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    flag_d = flag_q;
    if (apply_i && flag_q) begin
      act_d  = pend_q;
      flag_d = 1'b0;
    end
    if (cfg_update_i) begin
      pend_d = cfg_i;
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      act_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      flag_q <= flag_d;
    end
  end

  assign active_o = act_q;

endmodule

// File: rtl/modulation_sequencer.sv
// Modulation BRAM read sequencer: steps the read address at a divided tick
// rate, wraps at a programmable length and registers the returned samples.
module modulation_sequencer
  import modulation_pkg::*;
#(
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH   = MOD_ADDR_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        TICK,
  input  logic                        SYNC,
  input  logic                        ENABLE,
  input  logic [ADDR_WIDTH-1:0]       CYCLE_LAST,
  input  logic [ADDR_WIDTH-1:0]       FREQ_DIV,
  input  logic                        CFG_UPDATE,
  output logic [ADDR_WIDTH-1:0]       ADDR,
  input  logic [MOD_SAMPLE_WIDTH-1:0] MOD_IN,
  output logic [MOD_SAMPLE_WIDTH-1:0] MOD_OUT,
  output logic                        MOD_VALID,
  output logic                        CYCLE_WRAP
);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
  // One stage beyond the BRAM latency: MOD_IN is sampled the cycle after it settles.
  logic [BRAM_LATENCY:0]       vld_q, vld_d;
  logic [MOD_SAMPLE_WIDTH-1:0] out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        wrap_q, wrap_d;

  logic     idle_apply, clear, go, run;
  logic     do_sync, tick_hit, at_last, wrap, issue;
  mod_cfg_t cfg_in, active_cfg;

  always_comb begin
    cfg_in            = '0;
    cfg_in.cycle_last = CYCLE_LAST;
    cfg_in.freq_div   = FREQ_DIV;
  end

  mod_cfg_shadow u_cfg_shadow (
    .clk_i        (CLK),
    .rst_i        (RST),
    .cfg_update_i (CFG_UPDATE),
    .cfg_i        (cfg_in),
    .apply_i      (idle_apply | wrap),
    .active_o     (active_cfg)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ENABLE)  state_d = RUN;
      RUN:     if (!ENABLE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_apply = 1'b0;
    clear      = 1'b0;
    go         = 1'b0;
    run        = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_apply = 1'b1;
        clear      = 1'b1;
        go         = ENABLE;
      end
      RUN: begin
        clear = !ENABLE;
        run   = ENABLE;
      end
      default: clear = 1'b1;
    endcase
  end

  always_comb begin
    do_sync  = run && SYNC;
    tick_hit = run && !SYNC && TICK && (cnt_q == active_cfg.freq_div);
    at_last  = (addr_q >= active_cfg.cycle_last);
    wrap     = do_sync || (tick_hit && at_last);
    issue    = go || do_sync || tick_hit;
  end

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    vld_d   = {vld_q[BRAM_LATENCY-1:0], issue};
    out_d   = vld_q[BRAM_LATENCY] ? MOD_IN : out_q;
    valid_d = vld_q[BRAM_LATENCY];
    wrap_d  = wrap;
    if (clear) begin
      addr_d   = '0;
      cnt_d    = '0;
      vld_d    = '0;
      vld_d[0] = go;
      out_d    = '0;
      valid_d  = 1'b0;
    end else if (do_sync) begin
      addr_d = '0;
      cnt_d  = '0;
    end else if (run && TICK) begin
      if (tick_hit) begin
        cnt_d  = '0;
        addr_d = at_last ? '0 : addr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ADDR       = addr_q;
  assign MOD_OUT    = out_q;
  assign MOD_VALID  = valid_q;
  assign CYCLE_WRAP = wrap_q;

endmodule

// File: tb/tb_modulation_sequencer.sv
// Self-checking bench for modulation_sequencer with a latency-modelled BRAM.
module tb_modulation_sequencer;

  localparam int unsigned LAT = 2;

  logic        CLK = 1'b0;
  logic        RST, TICK, SYNC, ENABLE, CFG_UPDATE;
  logic [15:0] CYCLE_LAST, FREQ_DIV, ADDR;
  logic [7:0]  MOD_IN, MOD_OUT;
  logic        MOD_VALID, CYCLE_WRAP;

  always #5 CLK = ~CLK;

  modulation_sequencer #(.BRAM_LATENCY(LAT), .ADDR_WIDTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TICK       (TICK),
    .SYNC       (SYNC),
    .ENABLE     (ENABLE),
    .CYCLE_LAST (CYCLE_LAST),
    .FREQ_DIV   (FREQ_DIV),
    .CFG_UPDATE (CFG_UPDATE),
    .ADDR       (ADDR),
    .MOD_IN     (MOD_IN),
    .MOD_OUT    (MOD_OUT),
    .MOD_VALID  (MOD_VALID),
    .CYCLE_WRAP (CYCLE_WRAP)
  );

  logic [7:0] mem [16];
  logic [7:0] rd_pipe [LAT];

  always @(posedge CLK) begin
    rd_pipe[0] <= mem[ADDR[3:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign MOD_IN = rd_pipe[LAT-1];

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  int unsigned cyc = 0;
  bit          m_run, m_wrap, m_pflag;
  logic [15:0] m_addr, m_cnt, m_act_last, m_act_div, m_pend_last, m_pend_div;
  logic [7:0]  m_out;

  // Advance the reference model across the coming edge, then compare.
  task automatic cycle();
    bit   issue, apply, exp_valid;
    exp_t e;
    issue  = 0;
    apply  = 0;
    m_wrap = 0;
    if (RST) begin
      m_run = 0; m_addr = '0; m_cnt = '0; m_out = '0; m_pflag = 0;
      m_act_last = '0; m_act_div = '0; m_pend_last = '0; m_pend_div = '0;
      sb.delete();
    end else begin
      if (!m_run) begin
        apply = 1; m_addr = '0; m_cnt = '0;
        if (ENABLE) begin m_run = 1; issue = 1; end
      end else if (!ENABLE) begin
        m_run = 0; m_addr = '0; m_cnt = '0; m_out = '0;
        sb.delete();
      end else if (SYNC) begin
        m_addr = '0; m_cnt = '0; apply = 1; m_wrap = 1; issue = 1;
      end else if (TICK) begin
        if (m_cnt == m_act_div) begin
          m_cnt = '0; issue = 1;
          if (m_addr >= m_act_last) begin m_addr = '0; m_wrap = 1; apply = 1; end
          else m_addr = m_addr + 16'd1;
        end else begin
          m_cnt = m_cnt + 16'd1;
        end
      end
      if (apply && m_pflag) begin
        m_act_last = m_pend_last; m_act_div = m_pend_div; m_pflag = 0;
      end
      if (CFG_UPDATE) begin
        m_pend_last = CYCLE_LAST; m_pend_div = FREQ_DIV; m_pflag = 1;
      end
      if (issue) begin
        e.data = mem[m_addr[3:0]];
        e.due  = cyc + 1 + LAT + 1;
        sb.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    exp_valid = 0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_valid = 1;
      e = sb.pop_front();
      m_out = e.data;
    end
    check("addr", ADDR, m_addr);
    check("wrap", CYCLE_WRAP, m_wrap);
    check("valid", MOD_VALID, exp_valid);
    check("mod_out", MOD_OUT, m_out);
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int unsigned n = 0;
    while (ADDR != a && n < 64) begin
      cycle();
      n++;
    end
    if (ADDR != a) check("wait_addr", ADDR, a);
  endtask

  initial begin
    int unsigned shadow_exp[9] = '{2, 3, 0, 1, 2, 3, 4, 5, 0};
    int unsigned coinc_exp[10] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 0};
    int unsigned changes, valids;
    logic [15:0] prev;

    for (int i = 0; i < 16; i++) mem[i] = 8'((i + 1) * 16);
    RST = 1; TICK = 0; SYNC = 0; ENABLE = 0; CFG_UPDATE = 0;
    CYCLE_LAST = '0; FREQ_DIV = '0;
    repeat (4) cycle();
    check("rst_addr", ADDR, 0);
    check("rst_out", MOD_OUT, 0);
    check("rst_valid", MOD_VALID, 0);
    check("rst_wrap", CYCLE_WRAP, 0);

    // Configure in IDLE, then run with a tick every cycle
    RST = 0; CYCLE_LAST = 16'd3; FREQ_DIV = '0; CFG_UPDATE = 1;
    cycle();
    CFG_UPDATE = 0;
    cycle();
    ENABLE = 1; TICK = 1;
    cycle();
    check("en_addr", ADDR, 0);
    for (int i = 1; i < 8; i++) begin
      cycle();
      check("seq", ADDR, i % 4);
      if (i == 3) check("first_sample", MOD_OUT, 8'h10);
      if (i == 4) check("wrap_3to0", CYCLE_WRAP, 1);
    end

    // Shadow config: update at ADDR=1 takes effect at the next wrap
    wait_addr(16'd1);
    CYCLE_LAST = 16'd5; CFG_UPDATE = 1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      CFG_UPDATE = 0;
      check("shadow_seq", ADDR, shadow_exp[i]);
    end

    // SYNC with TICK at ADDR=2
    wait_addr(16'd2);
    SYNC = 1;
    cycle();
    SYNC = 0;
    check("sync_addr", ADDR, 0);
    check("sync_wrap", CYCLE_WRAP, 1);
    cycle();
    check("sync_next", ADDR, 1);

    // CFG_UPDATE on the wrap cycle applies one wrap later
    wait_addr(16'd5);
    CYCLE_LAST = 16'd2; CFG_UPDATE = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      CFG_UPDATE = 0;
      check("coinc_seq", ADDR, coinc_exp[i]);
    end

    // Disable with reads in flight, then SYNC while disabled
    wait_addr(16'd2);
    ENABLE = 0;
    cycle();
    check("dis_addr", ADDR, 0);
    check("dis_out", MOD_OUT, 0);
    check("dis_valid", MOD_VALID, 0);
    SYNC = 1;
    cycle();
    SYNC = 0;
    check("idle_sync_addr", ADDR, 0);
    check("idle_sync_wrap", CYCLE_WRAP, 0);
    repeat (4) cycle();

    // Reset mid-run; cleared config then gives the degenerate case
    ENABLE = 1;
    cycle();
    wait_addr(16'd2);
    RST = 1;
    cycle();
    RST = 0;
    check("mrst_addr", ADDR, 0);
    check("mrst_out", MOD_OUT, 0);
    check("mrst_valid", MOD_VALID, 0);
    repeat (6) cycle();
    check("degen_addr", ADDR, 0);
    check("degen_wrap", CYCLE_WRAP, 1);
    check("degen_out", MOD_OUT, 8'h10);

    // Divider: step every third tick, tick every fifth cycle
    CYCLE_LAST = 16'd3; FREQ_DIV = 16'd2; CFG_UPDATE = 1;
    cycle();
    CFG_UPDATE = 0;
    cycle();
    changes = 0;
    valids  = 0;
    for (int i = 0; i < 80; i++) begin
      TICK = (i % 5 == 0);
      prev = ADDR;
      cycle();
      if (ADDR != prev) changes++;
      if (i >= 5 && MOD_VALID) valids++;
    end
    TICK = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (MOD_VALID) valids++;
    end
    check("div_steps", changes, 5);
    check("div_valids", valids, 5);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
